// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load/flush sequencer for the five pipeline-register banks
//
// Resolves load-use hazards (one bubble), taken branches (flush IF/ID and ID/EX)
// and multi-cycle data-memory accesses (freeze the pipe, abort after MEM_TIMEOUT).
// Optional build macro PIPE_PERF_CNT_EN adds saturating performance counters.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_rs1, id_rs2, ex_rd          register specifiers for hazard detection
//   ex_memread, ex_branch_taken    EX-stage load / taken-branch indicators
//   mem_req, mem_ack               data-memory request outstanding / completes
//   pc_load .. memwb_load          per-bank load enables
//   ifid_flush, idex_flush         insert NOP / bubble into IF/ID, ID/EX
//   mem_err                        one-cycle pulse on memory timeout
//   stall                          any load enable deasserted this cycle
//   perf_stall_cycles, perf_flushes, perf_mem_errs  (PIPE_PERF_CNT_EN only)
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memread,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  pc_load,
    output logic                  ifid_load,
    output logic                  idex_load,
    output logic                  exmem_load,
    output logic                  memwb_load,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  mem_err,
    output logic                  stall
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flushes,
    output logic [31:0]           perf_mem_errs
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ABORT    = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [TO_W-1:0] cnt, cnt_d;
    logic            hz;
    logic            advance;

    // A zero destination is x0 and can never carry a loaded value.
    assign hz = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        pc_load    = 1'b0;
        ifid_load  = 1'b0;
        idex_load  = 1'b0;
        exmem_load = 1'b0;
        memwb_load = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mem_err    = 1'b0;
        state_d    = state;
        cnt_d      = cnt;
        advance    = 1'b0;

        if (rst) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            case (state)
                RUN: begin
                    // An outstanding access freezes everything; branch/hazard
                    // stay visible in the frozen EX/ID and are handled later.
                    if (mem_req && !mem_ack) begin
                        state_d = MEM_WAIT;
                        cnt_d   = TO_W'(1);
                    end else begin
                        advance = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        advance = 1'b1;
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (cnt == TO_W'(MEM_TIMEOUT)) begin
                        state_d = ABORT;
                    end else begin
                        cnt_d = cnt + TO_W'(1);
                    end
                end
                ABORT: begin
                    pc_load    = 1'b1;
                    ifid_load  = 1'b1;
                    idex_load  = 1'b1;
                    exmem_load = 1'b1;
                    memwb_load = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    mem_err    = 1'b1;
                    state_d    = RUN;
                    cnt_d      = '0;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase

            // Pipe is allowed to move: branch flush beats the load-use bubble.
            if (advance) begin
                exmem_load = 1'b1;
                memwb_load = 1'b1;
                idex_load  = 1'b1;
                if (ex_branch_taken) begin
                    pc_load    = 1'b1;
                    ifid_load  = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (hz) begin
                    idex_flush = 1'b1;
                end else begin
                    pc_load   = 1'b1;
                    ifid_load = 1'b1;
                end
            end
        end

        stall = !rst && !(pc_load && ifid_load && idex_load && exmem_load && memwb_load);
    end

    always_ff @(posedge clk) begin
        state <= state_d;
        cnt   <= cnt_d;
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_mem_errs     <= '0;
        end else begin
            if (stall && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (ifid_flush && (perf_flushes != '1)) perf_flushes      <= perf_flushes + 32'd1;
            if (mem_err && (perf_mem_errs != '1))   perf_mem_errs     <= perf_mem_errs + 32'd1;
        end
    end
`endif

endmodule
